// File: rtl/fetch_ctrl_16b_if.sv
// Fetch-controller bus: memory read port, PC/IR register strobes and decode
// handshake. master = fetch controller, slave = memory/registers/decode side.
interface fetch_ctrl_16b_if;
    logic        run;
    logic [15:0] pc_q;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic [15:0] ir_D;
    logic        ir_write;
    logic [15:0] pc_D;
    logic        pc_write;
    logic        br_take;
    logic [15:0] br_target;
    logic        instr_valid;
    logic        dec_ready;
    logic        fault;
    logic        clear_fault;

    modport master (
        input  run, pc_q, mem_ready, mem_rdata, br_take, br_target, dec_ready, clear_fault,
        output mem_addr, mem_rd, ir_D, ir_write, pc_D, pc_write, instr_valid, fault
    );

    modport slave (
        output run, pc_q, mem_ready, mem_rdata, br_take, br_target, dec_ready, clear_fault,
        input  mem_addr, mem_rd, ir_D, ir_write, pc_D, pc_write, instr_valid, fault
    );
endinterface

// File: rtl/fetch_ctrl_16b.sv
// Instruction-fetch sequencer: reads memory at pc_q, loads IR, advances or
// redirects the PC and hands the instruction to decode via valid/ready.
module fetch_ctrl_16b #(
    parameter int INC     = 2,
    parameter int TIMEOUT = 15
) (
    input logic CLK,
    input logic reset,
    fetch_ctrl_16b_if.master bus
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, VALID, FAULT} state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       squash, squash_nxt;
    logic       rd, irw, pcw, ival, flt;
    logic [15:0] pcd;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            squash <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            squash <= squash_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        squash_nxt = squash;
        rd   = 1'b0;
        irw  = 1'b0;
        pcw  = 1'b0;
        ival = 1'b0;
        flt  = 1'b0;
        pcd  = bus.pc_q + 16'(INC);
        case (state)
            IDLE: begin
                if (bus.br_take) begin
                    pcw = 1'b1;
                    pcd = bus.br_target;
                end
                if (bus.run) state_nxt = REQ;
            end
            REQ, WAIT: begin
                rd = 1'b1;
                if (bus.mem_ready) begin
                    // A branch now or one taken earlier in this fetch voids the data
                    cnt_nxt    = '0;
                    squash_nxt = 1'b0;
                    if (bus.br_take) begin
                        pcw       = 1'b1;
                        pcd       = bus.br_target;
                        state_nxt = REQ;
                    end else if (squash) begin
                        state_nxt = REQ;
                    end else begin
                        irw       = 1'b1;
                        pcw       = 1'b1;
                        state_nxt = VALID;
                    end
                end else begin
                    if (bus.br_take) begin
                        pcw        = 1'b1;
                        pcd        = bus.br_target;
                        squash_nxt = 1'b1;
                    end
                    if (state == REQ) begin
                        state_nxt = WAIT;
                        cnt_nxt   = 8'd1;
                    end else if (cnt >= 8'(TIMEOUT)) begin
                        state_nxt = FAULT;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
            end
            VALID: begin
                ival = 1'b1;
                if (bus.br_take) begin
                    pcw = 1'b1;
                    pcd = bus.br_target;
                end
                if (bus.br_take || bus.dec_ready)
                    state_nxt = bus.run ? REQ : IDLE;
            end
            FAULT: begin
                flt = 1'b1;
                if (bus.clear_fault) begin
                    state_nxt  = IDLE;
                    cnt_nxt    = '0;
                    squash_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are gated by reset so they drop the moment reset asserts
    assign bus.mem_rd      = rd   & reset;
    assign bus.ir_write    = irw  & reset;
    assign bus.pc_write    = pcw  & reset;
    assign bus.instr_valid = ival & reset;
    assign bus.fault       = flt  & reset;
    assign bus.pc_D        = pcd;
    assign bus.mem_addr    = bus.pc_q;
    assign bus.ir_D        = bus.mem_rdata;
endmodule

// File: tb/tb_fetch_ctrl_16b.sv
// Directed bench for fetch_ctrl_16b: stimulus pushes expected PC/IR strobes
// into a scoreboard; a negedge monitor pops and compares every strobe.
module tb_fetch_ctrl_16b;
    logic CLK = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    typedef struct packed {
        logic        irw;
        logic        pcw;
        logic [15:0] pcd;
        logic [15:0] ird;
    } exp_t;
    exp_t sbq[$];

    fetch_ctrl_16b_if bus();

    fetch_ctrl_16b #(.INC(2), .TIMEOUT(15)) dut (
        .CLK  (CLK),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic irw, input logic [15:0] pcd, input logic [15:0] ird);
        exp_t e;
        e.irw = irw;
        e.pcw = 1'b1;
        e.pcd = pcd;
        e.ird = ird;
        sbq.push_back(e);
    endtask

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: any PC/IR strobe must match the oldest outstanding expectation
    always @(negedge CLK) begin
        if (reset === 1'b1 && (bus.ir_write === 1'b1 || bus.pc_write === 1'b1)) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_strobe: got ir_write=%b pc_write=%b pc_D=%h expected none at %0t",
                         bus.ir_write, bus.pc_write, bus.pc_D, $time);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_ir_write", 16'(bus.ir_write), 16'(e.irw));
                chk("sb_pc_write", 16'(bus.pc_write), 16'(e.pcw));
                chk("sb_pc_D", bus.pc_D, e.pcd);
                if (e.irw) chk("sb_ir_D", bus.ir_D, e.ird);
            end
        end
    end

    initial begin
        reset           = 1'b0;
        bus.run         = 1'b0;
        bus.pc_q        = 16'h0100;
        bus.mem_ready   = 1'b0;
        bus.mem_rdata   = 16'hA5C3;
        bus.br_take     = 1'b0;
        bus.br_target   = 16'h0000;
        bus.dec_ready   = 1'b1;
        bus.clear_fault = 1'b0;
        nxt(); nxt();
        chk("rst_mem_rd", 16'(bus.mem_rd), 16'h0);
        chk("rst_ir_write", 16'(bus.ir_write), 16'h0);
        chk("rst_pc_write", 16'(bus.pc_write), 16'h0);
        chk("rst_instr_valid", 16'(bus.instr_valid), 16'h0);
        chk("rst_fault", 16'(bus.fault), 16'h0);
        chk("mem_addr_follows_pc", bus.mem_addr, 16'h0100);
        chk("ir_D_follows_rdata", bus.ir_D, 16'hA5C3);

        // Zero-wait fetch: one instruction every two cycles
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        bus.run = 1'b1;
        #1 chk("idle_no_rd", 16'(bus.mem_rd), 16'h0);
        for (int i = 0; i < 2; i++) begin
            nxt();
            push(1'b1, 16'h0102, 16'hA5C3);
            #1 chk("zw_req_rd", 16'(bus.mem_rd), 16'h1);
            chk("zw_req_novalid", 16'(bus.instr_valid), 16'h0);
            nxt();
            if (i == 1) bus.run = 1'b0;
            #1 chk("zw_valid", 16'(bus.instr_valid), 16'h1);
            chk("zw_valid_no_rd", 16'(bus.mem_rd), 16'h0);
        end
        nxt();
        #1 chk("zw_idle_novalid", 16'(bus.instr_valid), 16'h0);

        // Wait states: ready three cycles after the request
        bus.mem_ready = 1'b0;
        bus.pc_q = 16'h0200;
        bus.mem_rdata = 16'h1234;
        bus.run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nxt();
            if (i == 3) begin
                bus.mem_ready = 1'b1;
                push(1'b1, 16'h0202, 16'h1234);
            end
            #1 chk("ws_rd_held", 16'(bus.mem_rd), 16'h1);
        end
        nxt();
        bus.run = 1'b0;
        #1 chk("ws_valid", 16'(bus.instr_valid), 16'h1);
        chk("ws_no_fault", 16'(bus.fault), 16'h0);
        nxt();

        // Timeout: 15 cycles in WAIT then FAULT; branch ignored in FAULT
        bus.mem_ready = 1'b0;
        bus.pc_q = 16'h0300;
        bus.run = 1'b1;
        nxt();
        for (int i = 0; i < 15; i++) nxt();
        #1 chk("to_last_wait_nofault", 16'(bus.fault), 16'h0);
        chk("to_last_wait_rd", 16'(bus.mem_rd), 16'h1);
        nxt();
        bus.br_take = 1'b1;
        bus.br_target = 16'h5555;
        #1 chk("to_fault", 16'(bus.fault), 16'h1);
        chk("to_fault_no_rd", 16'(bus.mem_rd), 16'h0);
        nxt();
        bus.br_take = 1'b0;
        #1 chk("to_fault_held", 16'(bus.fault), 16'h1);
        bus.clear_fault = 1'b1;
        nxt();
        bus.clear_fault = 1'b0;
        #1 chk("to_cleared", 16'(bus.fault), 16'h0);
        chk("to_idle_no_rd", 16'(bus.mem_rd), 16'h0);
        nxt();
        #1 chk("to_req_rd", 16'(bus.mem_rd), 16'h1);

        // Redirect during WAIT: squashed fetch, then refetch at the target
        nxt();
        bus.br_take = 1'b1;
        bus.br_target = 16'h2000;
        push(1'b0, 16'h2000, 16'h0000);
        #1 chk("rd_wait_rd", 16'(bus.mem_rd), 16'h1);
        nxt();
        bus.br_take = 1'b0;
        bus.pc_q = 16'h2000;
        #1 chk("rd_squash_rd_held", 16'(bus.mem_rd), 16'h1);
        nxt();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'hDEAD;
        #1 chk("rd_squash_no_irw", 16'(bus.ir_write), 16'h0);
        nxt();
        push(1'b1, 16'h2002, 16'hDEAD);
        bus.run = 1'b0;
        #1 chk("rd_refetch_rd", 16'(bus.mem_rd), 16'h1);
        chk("rd_refetch_addr", bus.mem_addr, 16'h2000);
        nxt();
        nxt();

        // Branch coincident with mem_ready: branch wins
        bus.run = 1'b1;
        bus.pc_q = 16'h0400;
        bus.mem_rdata = 16'h7777;
        nxt();
        bus.br_take = 1'b1;
        bus.br_target = 16'h3000;
        push(1'b0, 16'h3000, 16'h0000);
        #1 chk("bw_no_irw", 16'(bus.ir_write), 16'h0);
        nxt();
        bus.br_take = 1'b0;
        bus.pc_q = 16'h3000;
        push(1'b1, 16'h3002, 16'h7777);
        #1 chk("bw_req_again", 16'(bus.mem_rd), 16'h1);
        nxt();

        // PC wrap, then branch with dec_ready in VALID
        bus.pc_q = 16'hFFFE;
        nxt();
        push(1'b1, 16'h0000, 16'h7777);
        nxt();
        bus.br_take = 1'b1;
        bus.br_target = 16'h1234;
        bus.run = 1'b0;
        push(1'b0, 16'h1234, 16'h0000);
        #1 chk("vb_valid", 16'(bus.instr_valid), 16'h1);
        nxt();
        bus.br_take = 1'b0;
        #1 chk("vb_valid_dropped", 16'(bus.instr_valid), 16'h0);
        chk("vb_idle_no_rd", 16'(bus.mem_rd), 16'h0);

        // Async reset mid-WAIT
        bus.mem_ready = 1'b0;
        bus.run = 1'b1;
        nxt(); nxt(); nxt();
        #1 chk("ar_pre_rd", 16'(bus.mem_rd), 16'h1);
        #1 reset = 1'b0;
        #1 chk("ar_rd_drop", 16'(bus.mem_rd), 16'h0);
        chk("ar_irw_drop", 16'(bus.ir_write), 16'h0);
        chk("ar_pcw_drop", 16'(bus.pc_write), 16'h0);
        chk("ar_valid_drop", 16'(bus.instr_valid), 16'h0);
        bus.mem_ready = 1'b1;
        nxt();
        reset = 1'b1;
        #1 chk("ar_idle_no_rd", 16'(bus.mem_rd), 16'h0);
        chk("ar_idle_no_irw", 16'(bus.ir_write), 16'h0);
        bus.run = 1'b0;
        nxt(); nxt();

        chk("sb_drained", 16'(sbq.size()), 16'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
